// File: rtl/mult_result_accumulator_27bits_pkg.sv
// Shared widths, lane geometry and mode encodings for the multiplier result accumulator.
package mult_result_accumulator_27bits_pkg;

   localparam int ACC_WIDTH     = 64;
   localparam int LANE_WIDTH    = 21;
   localparam int NUM_LANES     = 3;
   localparam int LANE_BITS     = 18;
   localparam int LANE_SUM_BITS = LANE_BITS + 2;
   localparam int PROD_WIDTH    = 54;

   typedef enum logic {
      MODE_27X27   = 1'b0,
      MODE_SUM_9X9 = 1'b1
   } mode_e;

   typedef struct packed {
      mode_e                      mode;
      logic                       is_signed;
      logic                       acc_en;
      logic [PROD_WIDTH-1:0]      r0;
      logic [PROD_WIDTH-1:0]      r1;
      logic [2*NUM_LANES-1:0]     carry;
   } beat_t;

   // Lane k raw value: the two lane carry bits extend the first partial result.
   function automatic logic [LANE_SUM_BITS-1:0] lane_raw(
      input logic [1:0]           carry,
      input logic [LANE_BITS-1:0] p0,
      input logic [LANE_BITS-1:0] p1
   );
      return {carry, p0} + {2'b00, p1};
   endfunction

endpackage

// File: rtl/mult_result_accumulator_27bits_lane_accumulate.sv
// Single-field wrap-around adder reporting signed overflow or unsigned carry-out.
module lane_accumulate #(
   parameter int WIDTH = 21
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] addend,
   input  logic             is_signed,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);

   logic carry;

   assign {carry, sum} = {1'b0, acc} + {1'b0, addend};

   // Signed overflow: operands agree in sign but the result does not.
   assign overflow = is_signed ? ((acc[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]))
                               : carry;

endmodule

// File: rtl/mult_result_accumulator_27bits.sv
// Two-stage accumulator for 27x27 products or three packed sum-of-9x9 lanes,
// with sticky per-lane overflow and implicit load on mode change.
module mult_result_accumulator_27bits #(
   parameter int ACC_WIDTH  = mult_result_accumulator_27bits_pkg::ACC_WIDTH,
   parameter int LANE_WIDTH = mult_result_accumulator_27bits_pkg::LANE_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 mode,
   input  logic                 a_sign,
   input  logic                 b_sign,
   input  logic [53:0]          result_0,
   input  logic [53:0]          result_1,
   input  logic [5:0]           result_SIMD_carry,
   input  logic                 acc_en,
   output logic [ACC_WIDTH-1:0] acc_out,
   output logic                 out_valid,
   output logic [2:0]           overflow
);

   import mult_result_accumulator_27bits_pkg::*;

   logic                 s1_valid;
   beat_t                s1;
   logic [ACC_WIDTH-1:0] acc_q;
   mode_e                mode_q;
   logic                 empty_q;

   // Stage 1: capture the beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) s1_valid <= 1'b0;
      else       s1_valid <= in_valid;
   end

   // NOTE: the captured beat is only consumed when s1_valid is set, so these
   // datapath registers carry no reset and stay out of the async-reset block.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         s1.mode      <= mode_e'(mode);
         s1.is_signed <= a_sign | b_sign;
         s1.acc_en    <= acc_en;
         s1.r0        <= result_0;
         s1.r1        <= result_1;
         s1.carry     <= result_SIMD_carry;
      end
   end

   // Full-width product path.
   logic [PROD_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]  prod_ext;
   logic [ACC_WIDTH-1:0]  full_sum;
   logic                  full_ovf;

   assign prod     = s1.r0 + s1.r1;
   assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){s1.is_signed & prod[PROD_WIDTH-1]}}, prod};

   lane_accumulate #(.WIDTH(ACC_WIDTH)) u_full (
      .acc       (acc_q),
      .addend    (prod_ext),
      .is_signed (s1.is_signed),
      .sum       (full_sum),
      .overflow  (full_ovf)
   );

   // SIMD lane paths.
   logic [LANE_WIDTH-1:0] lane_addend [NUM_LANES];
   logic [LANE_WIDTH-1:0] lane_sum    [NUM_LANES];
   logic [NUM_LANES-1:0]  lane_ovf;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [LANE_SUM_BITS-1:0] raw;

      assign raw = lane_raw(s1.carry[2*k +: 2],
                            s1.r0[LANE_BITS*k +: LANE_BITS],
                            s1.r1[LANE_BITS*k +: LANE_BITS]);
      assign lane_addend[k] = {{(LANE_WIDTH-LANE_SUM_BITS){s1.is_signed & raw[LANE_SUM_BITS-1]}}, raw};

      lane_accumulate #(.WIDTH(LANE_WIDTH)) u_lane (
         .acc       (acc_q[LANE_WIDTH*k +: LANE_WIDTH]),
         .addend    (lane_addend[k]),
         .is_signed (s1.is_signed),
         .sum       (lane_sum[k]),
         .overflow  (lane_ovf[k])
      );
   end

   // Pack lanes; bits above the last lane stay zero.
   logic [ACC_WIDTH-1:0] simd_load;
   logic [ACC_WIDTH-1:0] simd_sum;
   logic                 load_beat;

   always_comb begin
      simd_load = '0;
      simd_sum  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         simd_load[LANE_WIDTH*k +: LANE_WIDTH] = lane_addend[k];
         simd_sum[LANE_WIDTH*k +: LANE_WIDTH]  = lane_sum[k];
      end
   end

   assign load_beat = !s1.acc_en || empty_q || (s1.mode != mode_q);

   // Stage 2: accumulate or load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         out_valid <= 1'b0;
         overflow  <= '0;
         mode_q    <= MODE_27X27;
         empty_q   <= 1'b1;
      end else begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            mode_q  <= s1.mode;
            empty_q <= 1'b0;
            if (s1.mode == MODE_27X27) begin
               acc_q    <= load_beat ? prod_ext : full_sum;
               overflow <= load_beat ? '0 : {{(NUM_LANES-1){1'b0}}, overflow[0] | full_ovf};
            end else begin
               acc_q    <= load_beat ? simd_load : simd_sum;
               overflow <= load_beat ? '0 : (overflow | lane_ovf);
            end
         end
      end
   end

   assign acc_out = acc_q;

endmodule

// File: tb/tb_mult_result_accumulator_27bits.sv
// Scoreboard bench: a behavioural model predicts each beat's result; the monitor
// compares it when out_valid appears and checks the two-cycle latency.
module tb_mult_result_accumulator_27bits;

   localparam int P = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        mode;
   logic        a_sign;
   logic        b_sign;
   logic [53:0] result_0;
   logic [53:0] result_1;
   logic [5:0]  result_SIMD_carry;
   logic        acc_en;
   logic [63:0] acc_out;
   logic        out_valid;
   logic [2:0]  overflow;

   mult_result_accumulator_27bits dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .mode              (mode),
      .a_sign            (a_sign),
      .b_sign            (b_sign),
      .result_0          (result_0),
      .result_1          (result_1),
      .result_SIMD_carry (result_SIMD_carry),
      .acc_en            (acc_en),
      .acc_out           (acc_out),
      .out_valid         (out_valid),
      .overflow          (overflow)
   );

   always #(P/2) clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [63:0] acc;
      logic [2:0]  ovf;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   // Reference model state.
   logic [63:0] m_acc;
   logic [2:0]  m_ovf;
   logic        m_mode;
   logic        m_empty;

   task automatic model_reset();
      m_acc   = '0;
      m_ovf   = '0;
      m_mode  = 1'b0;
      m_empty = 1'b1;
   endtask

   task automatic model_beat(input logic md, input logic sg, input logic [53:0] r0,
                             input logic [53:0] r1, input logic [5:0] cy, input logic en);
      logic               load;
      logic [54:0]        s;
      logic [63:0]        e64;
      logic [64:0]        t;
      logic signed [64:0] st;
      logic [63:0]        nacc;
      logic [2:0]         novf;
      load = !en || m_empty || (md != m_mode);
      nacc = '0;
      novf = '0;
      if (!md) begin
         s   = {1'b0, r0} + {1'b0, r1};
         e64 = sg ? {{10{s[53]}}, s[53:0]} : {10'b0, s[53:0]};
         t   = {1'b0, m_acc} + {1'b0, e64};
         st  = $signed({m_acc[63], m_acc}) + $signed({e64[63], e64});
         nacc = load ? e64 : t[63:0];
         novf[0] = load ? 1'b0 : (m_ovf[0] | (sg ? (st[64] ^ st[63]) : t[64]));
      end else begin
         for (int k = 0; k < 3; k++) begin
            logic [19:0]        v;
            logic [20:0]        e;
            logic [20:0]        a;
            logic [21:0]        lt;
            logic signed [21:0] lst;
            v   = {cy[2*k +: 2], r0[18*k +: 18]} + {2'b00, r1[18*k +: 18]};
            e   = sg ? {v[19], v} : {1'b0, v};
            a   = m_acc[21*k +: 21];
            lt  = {1'b0, a} + {1'b0, e};
            lst = $signed({a[20], a}) + $signed({e[20], e});
            nacc[21*k +: 21] = load ? e : lt[20:0];
            novf[k] = load ? 1'b0 : (m_ovf[k] | (sg ? (lst[21] ^ lst[20]) : lt[21]));
         end
      end
      m_acc   = nacc;
      m_ovf   = novf;
      m_mode  = md;
      m_empty = 1'b0;
   endtask

   task automatic beat(input string tag, input logic md, input logic sa, input logic sb_,
                       input logic [53:0] r0, input logic [53:0] r1, input logic [5:0] cy,
                       input logic en);
      @(negedge clk);
      in_valid          = 1'b1;
      mode              = md;
      a_sign            = sa;
      b_sign            = sb_;
      result_0          = r0;
      result_1          = r1;
      result_SIMD_carry = cy;
      acc_en            = en;
      model_beat(md, sa | sb_, r0, r1, cy, en);
      sb.push_back('{tag, m_acc, m_ovf, cyc});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      idle(3);
      for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: compare each output beat against the scoreboard head.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_acc"}, acc_out, e.acc);
            check({e.tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
            check({e.tag, "_latency"}, 64'(cyc - e.cyc), 64'd2);
         end
      end
   end

   initial begin
      #(P*5000);
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; mode = 1'b0; a_sign = 1'b0; b_sign = 1'b0;
      result_0 = '0; result_1 = '0; result_SIMD_carry = '0; acc_en = 1'b0;
      model_reset();
      #1;
      check("reset_acc", acc_out, 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Mode 0 unsigned load then add.
      beat("m0_load", 1'b0, 1'b0, 1'b0, 54'd100, 54'd23, 6'd0, 1'b0);
      beat("m0_add",  1'b0, 1'b0, 1'b0, 54'd7,   54'd0,  6'd0, 1'b1);
      drain();
      check("m0_acc_130", acc_out, 64'd130);

      // Signed negative load.
      beat("m0_neg", 1'b0, 1'b1, 1'b0, 54'h3F_FFFF_FFFF_FFFB, 54'd2, 6'd0, 1'b0);
      drain();
      check("m0_neg_acc", acc_out, 64'hFFFF_FFFF_FFFF_FFFD);
      check("m0_neg_ovf", 64'(overflow), 64'd0);

      // Unsigned add wraps with carry-out.
      beat("m0_carry", 1'b0, 1'b0, 1'b0, 54'd123, 54'd0, 6'd0, 1'b1);
      drain();
      check("m0_carry_acc", acc_out, 64'd120);
      check("m0_carry_ovf", 64'(overflow), 64'd1);

      // Mode switch with acc_en=1 loads and clears overflow.
      beat("m1_switch", 1'b1, 1'b0, 1'b0, 54'h3FFFF, 54'd1, 6'b000001, 1'b1);
      drain();
      check("m1_switch_acc", acc_out, 64'h80000);
      check("m1_switch_ovf", 64'(overflow), 64'd0);

      // Signed lane overflow, sticky until next load.
      beat("m1_s_load", 1'b1, 1'b0, 1'b1, 54'h3FFFF, 54'd0, 6'b000001, 1'b0);
      beat("m1_s_add1", 1'b1, 1'b0, 1'b1, 54'h3FFFF, 54'd0, 6'b000001, 1'b1);
      beat("m1_s_add2", 1'b1, 1'b0, 1'b1, 54'h3FFFF, 54'd0, 6'b000001, 1'b1);
      drain();
      check("m1_s_lane0", 64'(acc_out[20:0]), 64'h17FFFD);
      check("m1_s_ovf", 64'(overflow), 64'd1);
      beat("m1_s_sticky", 1'b1, 1'b0, 1'b1, 54'h3FFFF, 54'd0, 6'b000001, 1'b1);
      drain();
      check("m1_sticky_ovf", 64'(overflow), 64'd1);
      beat("m1_s_reload", 1'b1, 1'b0, 1'b1, 54'h3FFFF, 54'd0, 6'b000001, 1'b0);
      drain();
      check("m1_reload_ovf", 64'(overflow), 64'd0);

      // Idle cycles hold state.
      idle(5);
      check("idle_hold_acc", acc_out, m_acc);
      check("idle_hold_ovf", 64'(overflow), 64'(m_ovf));

      // Back-to-back random beats across both modes.
      for (int i = 0; i < 24; i++) begin
         logic [63:0] x0;
         logic [63:0] x1;
         x0 = {$urandom, $urandom};
         x1 = {$urandom, $urandom};
         beat($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, x0[53:0], x1[53:0], 6'($urandom),
              $urandom_range(0, 4) != 0);
      end
      drain();

      // Reset while one beat is on the output and one is in stage 1.
      beat("rst_a", 1'b0, 1'b0, 1'b0, 54'd100, 54'd1, 6'd0, 1'b0);
      beat("rst_b", 1'b0, 1'b0, 1'b0, 54'd200, 54'd2, 6'd0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #(P/4);
      reset = 1'b1;
      sb.delete();
      model_reset();
      #1;
      check("midrst_acc", acc_out, 64'd0);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_ovf", 64'(overflow), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_reset_quiet", 64'(out_valid), 64'd0);
      end

      // First beat after reset loads even with acc_en=1.
      beat("first_after_rst", 1'b0, 1'b0, 1'b0, 54'd5, 54'd6, 6'd0, 1'b1);
      drain();
      check("first_after_rst_acc", acc_out, 64'd11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_result_accumulator_27bits.md
MULT_RESULT_ACCUMULATOR_27BITS -- requirements
Module: mult_result_accumulator_27bits

Interface
REQ-001 The block SHALL have parameter ACC_WIDTH, default 64, meaning the full-mode accumulator width.
REQ-002 The block SHALL have parameter LANE_WIDTH, default 21, meaning the per-lane accumulator width in SIMD mode.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, which qualifies one multiplier beat.
REQ-006 The block SHALL have port mode, input, 1, where 0 = 27x27 and 1 = sum-of-three-9x9 SIMD.
REQ-007 The block SHALL have ports a_sign and b_sign, input, 1 each, carrying the operand signedness of the beat.
REQ-008 The block SHALL have ports result_0 and result_1, input, 54 each, carrying the multiplier partial results.
REQ-009 The block SHALL have port result_SIMD_carry, input, 6, carrying the lane carries, 2 bits per lane.
REQ-010 The block SHALL have port acc_en, input, 1, where 1 = add to the accumulator and 0 = load it.
REQ-011 The block SHALL have port acc_out, output, ACC_WIDTH, the accumulator value.
REQ-012 The block SHALL have port out_valid, output, 1, which is high for one cycle per accepted beat.
REQ-013 The block SHALL have port overflow, output, 3, holding sticky per-lane overflow flags.

Function
REQ-014 Stage 1 SHALL register every input when in_valid=1; stage 2 SHALL update the accumulator; out_valid SHALL rise exactly 2 cycles after the in_valid edge.
REQ-015 The pipeline SHALL accept a beat every cycle with no stalls, and in_valid=0 cycles SHALL leave the accumulator, acc_out and overflow unchanged.
REQ-016 In mode 0, the product SHALL be (result_0+result_1) mod 2^54, sign-extended to ACC_WIDTH if a_sign|b_sign and zero-extended otherwise.
REQ-017 In mode 1, lane k (k=0..2) SHALL be ({result_SIMD_carry[2k+1:2k], result_0[18k+17:18k]} + {2'b00, result_1[18k+17:18k]}) mod 2^20.
REQ-018 In mode 1, each lane SHALL be extended to LANE_WIDTH, signed if a_sign|b_sign and unsigned otherwise.
REQ-019 In mode 1, lane k SHALL occupy acc_out[21k+20:21k], and acc_out[63] SHALL be 0.
REQ-020 When acc_en=0, the accumulator SHALL load the product (or lanes) and clear overflow.
REQ-021 When acc_en=1, the accumulator SHALL add the product or lanes with wrap-around modulo the field width.
REQ-022 The overflow flag SHALL set on signed overflow when the beat is signed and on carry-out when it is unsigned; it SHALL stay set until the next load or reset.
REQ-023 In mode 0, only overflow[0] SHALL be used, and overflow[2:1] SHALL be 0.
REQ-024 A beat whose mode differs from the mode of the current accumulator contents SHALL be treated as a load regardless of acc_en.
REQ-025 The first beat after reset SHALL always be treated as a load.
REQ-026 The stored mode SHALL update with every accepted beat.

Reset
REQ-027 Asserting reset SHALL immediately force acc_out=0, out_valid=0, overflow=0, the stage-1 valid to 0, the stored mode to 0 and the "accumulator empty" flag to 1.
REQ-028 Reset asserted mid-pipeline SHALL discard in-flight beats, and no out_valid SHALL appear for them after release.

Structure
REQ-029 A shared package SHALL hold ACC_WIDTH, LANE_WIDTH, the lane count of 3, the lane width of 18, and the mode encodings MODE_27X27=0 and MODE_SUM_9X9=1.
REQ-030 One sub-module, lane_accumulate, SHALL implement a single-lane add with signed/unsigned overflow detection and SHALL be instantiated three times.
REQ-031 Mode 0 SHALL reuse lane_accumulate at ACC_WIDTH.

Verification
REQ-032 The bench SHALL cover: result_0=100, result_1=23, mode=0, unsigned, acc_en=0 -> acc_out=123, out_valid after 2 cycles; then result_0=7, result_1=0, acc_en=1 -> acc_out=130.
REQ-033 The bench SHALL cover: result_0=-5 (54-bit), result_1=2, a_sign=1, acc_en=0 -> acc_out=64'hFFFF_FFFF_FFFF_FFFD, overflow=0.
REQ-034 The bench SHALL cover: mode=1, unsigned, lane0 carry=2'b01, result_0[17:0]=18'h3FFFF, result_1[17:0]=1 -> acc_out[20:0]=21'h080000.
REQ-035 The bench SHALL cover: mode=1, signed, lane0 value 20'h7FFFF loaded, then accumulated twice -> 21'h0FFFFE with overflow[0]=0, then 21'h17FFFD with overflow[0]=1, which stays set until the next acc_en=0 beat.
REQ-036 The bench SHALL cover: a mode=0 beat followed by a mode=1 beat with acc_en=1 -> the mode=1 beat is loaded (not added) and overflow is cleared.
REQ-037 The bench SHALL cover: reset pulsed while two beats are in flight -> acc_out=0 and out_valid=0 immediately, with no out_valid pulse afterwards.
